// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and types for the multiplexed BCD display scanner.
// Segment vectors are {g,f,e,d,c,b,a}, active-high.
package bcd_display_scanner_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_e;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Counter-chain side inputs and display-pin side outputs of the scanner.
// master drives digits/controls, slave is the scanner itself.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 6
);
  import bcd_display_scanner_pkg::*;

  logic                    en;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_blank;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic [2:0]              digit_idx;
  logic                    frame_start;

  modport master (
    output en, bcd_in, dp_in, blank_mask, blink_mask, lz_blank,
    input  seg, dp, an, digit_idx, frame_start
  );

  modport slave (
    input  en, bcd_in, dp_in, blank_mask, blink_mask, lz_blank,
    output seg, dp, an, digit_idx, frame_start
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// BCD to 7-segment decoder; codes 10..15 show a dash.
// Output polarity is applied here so the pins need no further inversion.
module bcd_to_7seg
  import bcd_display_scanner_pkg::*;
#(
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_act;

  // Active-high segment pattern, then pin polarity
  always_comb begin
    seg_act = SEG_DASH;
    unique case (bcd_i)
      4'd0:    seg_act = SEG_0;
      4'd1:    seg_act = SEG_1;
      4'd2:    seg_act = SEG_2;
      4'd3:    seg_act = SEG_3;
      4'd4:    seg_act = SEG_4;
      4'd5:    seg_act = SEG_5;
      4'd6:    seg_act = SEG_6;
      4'd7:    seg_act = SEG_7;
      4'd8:    seg_act = SEG_8;
      4'd9:    seg_act = SEG_9;
      default: seg_act = SEG_DASH;
    endcase
    seg_o = seg_act ^ {7{SEG_ACT_LOW}};
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner: frame snapshot, leading-zero
// blanking, blink and a dead interval at the start of every digit slot.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYC     = 64,
  parameter int BLINK_FRAMES = 64,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit AN_ACT_LOW   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  bcd_display_scanner_if.slave bus
);

  localparam int N  = NUM_DIGITS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0]   SEG_IDLE = SEG_OFF ^ {7{SEG_ACT_LOW}};
  localparam logic [N-1:0] AN_IDLE  = {N{AN_ACT_LOW}};

  logic [PW-1:0]  presc_q, presc_d;
  logic [2:0]     dig_q, dig_d;
  logic           slot_end, frame_end;

  logic [4*N-1:0] snap_bcd_q;
  logic [N-1:0]   snap_dp_q;
  logic [N-1:0]   snap_blank_q;
  logic [N-1:0]   snap_blink_q;
  logic           snap_vld_q;
  logic           snap_ld;

  blink_e         blink_q, blink_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic           blink_off;

  logic [3:0]     cur_bcd;
  logic           cur_dp, cur_blank, cur_blink, cur_lz;
  logic           zero_run, dark, lit;
  logic [6:0]     seg_dec;

  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;
  logic [N-1:0]   an_q, an_d;
  logic [2:0]     idx_q;
  logic           fs_q, fs_d;

  // Prescaler and digit counter advance; both hold while disabled
  always_comb begin
    slot_end  = bus.en && (presc_q == PW'(SCAN_DIV - 1));
    frame_end = slot_end && (dig_q == 3'(N - 1));
    presc_d   = presc_q;
    dig_d     = dig_q;
    if (bus.en) begin
      if (slot_end) begin
        presc_d = '0;
        dig_d   = frame_end ? 3'd0 : dig_q + 3'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Scan counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      dig_q   <= '0;
    end else begin
      presc_q <= presc_d;
      dig_q   <= dig_d;
    end
  end

  // Snapshot on frame wrap; the first enabled cycle after reset also
  // loads so the very first frame shows live data instead of zeros
  assign snap_ld = bus.en && (frame_end || !snap_vld_q);

  // Frame-coherent copy of digit data and masks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_bcd_q   <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      snap_blink_q <= '0;
      snap_vld_q   <= 1'b0;
    end else if (snap_ld) begin
      snap_bcd_q   <= bus.bcd_in;
      snap_dp_q    <= bus.dp_in;
      snap_blank_q <= bus.blank_mask;
      snap_blink_q <= bus.blink_mask;
      snap_vld_q   <= 1'b1;
    end
  end

  // Blink state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_q <= BLINK_ON;
      bcnt_q  <= '0;
    end else begin
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Blink next state: toggle phase every BLINK_FRAMES frames
  always_comb begin
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (frame_end) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        blink_d = (blink_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Blink output decode
  always_comb begin
    blink_off = (blink_q == BLINK_OFF);
  end

  // Select current digit and walk zeros down from the top for LZ
  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    zero_run  = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      zero_run = zero_run && (snap_bcd_q[4*i +: 4] == 4'd0);
      if (dig_q == 3'(i)) begin
        cur_bcd   = snap_bcd_q[4*i +: 4];
        cur_dp    = snap_dp_q[i];
        cur_blank = snap_blank_q[i];
        cur_blink = snap_blink_q[i];
        cur_lz    = bus.lz_blank && zero_run && (i != 0);
      end
    end
    dark = cur_blank || (cur_blink && blink_off) || cur_lz;
    lit  = bus.en && (presc_q >= PW'(DEAD_CYC)) && !dark;
  end

  bcd_to_7seg #(
    .SEG_ACT_LOW (SEG_ACT_LOW)
  ) u_dec (
    .bcd_i (cur_bcd),
    .seg_o (seg_dec)
  );

  // Pin values for the next cycle; segments stay off while not lit
  always_comb begin
    an_d = AN_IDLE;
    for (int i = 0; i < N; i++) begin
      if (lit && (dig_q == 3'(i))) begin
        an_d[i] = ~AN_ACT_LOW;
      end
    end
    seg_d = lit ? seg_dec : SEG_IDLE;
    dp_d  = lit ? (cur_dp ^ SEG_ACT_LOW) : SEG_ACT_LOW;
    fs_d  = bus.en && (presc_q == '0) && (dig_q == 3'd0);
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= AN_IDLE;
      seg_q <= SEG_IDLE;
      dp_q  <= SEG_ACT_LOW;
      idx_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      idx_q <= dig_q;
      fs_q  <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner (4 digits, 8-cycle slots).
// Reference model works from the absolute enabled-cycle count.
module tb_bcd_display_scanner;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam int BF = 2;
  localparam int FR = ND * SD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  bcd_display_scanner #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .DEAD_CYC     (DC),
    .BLINK_FRAMES (BF),
    .SEG_ACT_LOW  (1'b0),
    .AN_ACT_LOW   (1'b0)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] tbl [16];

  int         k;
  logic [15:0] m_bcd;
  logic [3:0] m_dp, m_blank, m_blink;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_fs;
  logic [2:0] e_idx;
  int         e_p, e_s;

  task automatic step();
    int p, s, f, d;
    logic off, dark, lit;
    @(posedge clk);
    if (rst) begin
      k = 0; m_bcd = '0; m_dp = '0; m_blank = '0; m_blink = '0;
      e_an = '0; e_seg = '0; e_dp = 1'b0; e_fs = 1'b0; e_idx = '0;
      e_p = 0; e_s = 0;
    end else if (bus.en) begin
      p = k % SD;
      s = (k / SD) % ND;
      f = k / FR;
      off = ((f / BF) % 2) == 1;
      d = int'((m_bcd >> (4 * s)) & 16'hF);
      dark = m_blank[s] || (m_blink[s] && off) ||
             (bus.lz_blank && s > 0 && (m_bcd >> (4 * s)) == 16'h0);
      lit = (p >= DC) && !dark;
      e_an  = lit ? 4'(1 << s) : 4'b0;
      e_seg = lit ? tbl[d] : 7'b0;
      e_dp  = lit && m_dp[s];
      e_idx = 3'(s);
      e_fs  = (p == 0) && (s == 0);
      e_p = p; e_s = s;
      if (k == 0 || (k % FR) == FR - 1) begin
        m_bcd = bus.bcd_in; m_dp = bus.dp_in;
        m_blank = bus.blank_mask; m_blink = bus.blink_mask;
      end
      k++;
    end else begin
      e_an = '0; e_seg = '0; e_dp = 1'b0; e_fs = 1'b0;
      e_p = k % SD; e_s = (k / SD) % ND;
      e_idx = 3'(e_s);
    end
    #1;
  endtask

  task automatic run_to_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while ((k % FR) != 0 && n < 2 * FR);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.bcd_in = 16'h1234; bus.dp_in = '0;
    bus.blank_mask = '0; bus.blink_mask = '0; bus.lz_blank = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (bus.an !== 4'b0 || bus.seg !== 7'b0 || bus.dp !== 1'b0 ||
          bus.frame_start !== 1'b0 || bus.digit_idx !== 3'd0) begin
        errors++;
        $display("FAIL reset: an=%b seg=%b dp=%b fs=%b idx=%0d, required zeros",
                 bus.an, bus.seg, bus.dp, bus.frame_start, bus.digit_idx);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    int last = -1;
    int pulses = 0;
    for (int c = 1; c <= 72; c++) begin
      step();
      checks++;
      if (bus.an !== e_an || bus.seg !== e_seg) begin
        errors++;
        $display("FAIL scan_model c=%0d: an=%b seg=%b, required an=%b seg=%b",
                 c, bus.an, bus.seg, e_an, e_seg);
      end
      if (c >= 3 && c <= 8) begin
        checks++;
        if (bus.an !== 4'b0001 || bus.seg !== 7'b1100110) begin
          errors++;
          $display("FAIL scan_digit0 c=%0d: an=%b seg=%b, required 0001 1100110",
                   c, bus.an, bus.seg);
        end
      end
      if ((c - 3) % SD == 0) begin
        checks++;
        if (bus.an !== 4'(1 << (((c - 3) / SD) % ND))) begin
          errors++;
          $display("FAIL scan_order c=%0d: an=%b, required %b",
                   c, bus.an, 4'(1 << (((c - 3) / SD) % ND)));
        end
      end
      if (bus.frame_start === 1'b1) begin
        pulses++;
        checks++;
        if ((last < 0 && c != 1) || (last >= 0 && c - last != FR)) begin
          errors++;
          $display("FAIL frame_start c=%0d: last=%0d, required period 32 from c=1",
                   c, last);
        end
        last = c;
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL frame_count: got %0d, required 3", pulses);
    end
  endtask

  task automatic test_lz();
    int lit0 = 0;
    int lithi = 0;
    bus.bcd_in = 16'h0007; bus.lz_blank = 1'b1;
    run_to_frame();
    for (int c = 0; c < FR; c++) begin
      step();
      checks++;
      if (bus.an[3:1] !== 3'b0 || (bus.an[0] && bus.seg !== 7'b0000111)) begin
        errors++;
        $display("FAIL lz_on: an=%b seg=%b, required only an[0] with 0000111",
                 bus.an, bus.seg);
      end
      if (bus.an[0]) lit0++;
    end
    checks++;
    if (lit0 != SD - DC) begin
      errors++;
      $display("FAIL lz_on_count: got %0d, required %0d", lit0, SD - DC);
    end
    bus.lz_blank = 1'b0;
    run_to_frame();
    for (int c = 0; c < FR; c++) begin
      step();
      if (bus.an[3:1] != 3'b0 && bus.seg === 7'b0111111) lithi++;
    end
    checks++;
    if (lithi != 3 * (SD - DC)) begin
      errors++;
      $display("FAIL lz_off_count: got %0d, required %0d", lithi, 3 * (SD - DC));
    end
  endtask

  task automatic test_snapshot();
    int lit2 = 0;
    bus.bcd_in = 16'h1111;
    run_to_frame();
    repeat (12) step();
    bus.bcd_in = 16'h2222;
    for (int c = 12; c < FR; c++) begin
      step();
      checks++;
      if (bus.an != 4'b0 && bus.seg !== 7'b0000110) begin
        errors++;
        $display("FAIL snap_old: seg=%b, required 0000110", bus.seg);
      end
    end
    for (int c = 0; c < FR; c++) begin
      step();
      checks++;
      if (bus.an != 4'b0 && bus.seg !== 7'b1011011) begin
        errors++;
        $display("FAIL snap_new: seg=%b, required 1011011", bus.seg);
      end
      if (bus.an != 4'b0) lit2++;
    end
    checks++;
    if (lit2 != ND * (SD - DC)) begin
      errors++;
      $display("FAIL snap_count: got %0d, required %0d", lit2, ND * (SD - DC));
    end
  endtask

  task automatic test_blink();
    int cnt [ND];
    int f;
    logic off;
    bus.bcd_in = 16'h1234; bus.blink_mask = 4'b0010;
    run_to_frame();
    for (int fr = 0; fr < 8; fr++) begin
      f = k / FR;
      off = ((f / BF) % 2) == 1;
      for (int i = 0; i < ND; i++) cnt[i] = 0;
      for (int c = 0; c < FR; c++) begin
        step();
        for (int i = 0; i < ND; i++) if (bus.an[i]) cnt[i]++;
      end
      checks++;
      if (cnt[1] != (off ? 0 : SD - DC) ||
          cnt[0] + cnt[2] + cnt[3] != 3 * (SD - DC)) begin
        errors++;
        $display("FAIL blink f=%0d: d1=%0d others=%0d, required d1=%0d others=%0d",
                 f, cnt[1], cnt[0] + cnt[2] + cnt[3],
                 off ? 0 : SD - DC, 3 * (SD - DC));
      end
    end
    bus.blink_mask = 4'b0;
  endtask

  task automatic test_dp();
    int n2 = 0;
    bus.bcd_in = 16'h1B34; bus.dp_in = 4'b0100;
    run_to_frame();
    for (int c = 0; c < FR; c++) begin
      step();
      checks++;
      if (bus.an[2]) begin
        n2++;
        if (bus.seg !== 7'b1000000 || bus.dp !== 1'b1) begin
          errors++;
          $display("FAIL dash_dp: seg=%b dp=%b, required 1000000 1", bus.seg, bus.dp);
        end
      end else if (bus.dp !== 1'b0) begin
        errors++;
        $display("FAIL dp_other: dp=%b an=%b, required 0", bus.dp, bus.an);
      end
    end
    checks++;
    if (n2 != SD - DC) begin
      errors++;
      $display("FAIL dash_count: got %0d, required %0d", n2, SD - DC);
    end
    bus.blank_mask = 4'b0100;
    run_to_frame();
    for (int c = 0; c < FR; c++) begin
      step();
      checks++;
      if (bus.an[2] !== 1'b0 ||
          (bus.digit_idx == 3'd2 && (bus.seg !== 7'b0 || bus.dp !== 1'b0))) begin
        errors++;
        $display("FAIL blank: an=%b seg=%b dp=%b idx=%0d, required slot 2 dark",
                 bus.an, bus.seg, bus.dp, bus.digit_idx);
      end
    end
    bus.blank_mask = 4'b0; bus.dp_in = 4'b0;
  endtask

  task automatic test_enable();
    int slot;
    int n = 0;
    bus.bcd_in = 16'h1234;
    do begin step(); n++; end while (e_p != 4 && n < 2 * SD);
    slot = e_s;
    bus.en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (bus.an !== 4'b0 || bus.seg !== 7'b0 || bus.digit_idx !== 3'(slot)) begin
        errors++;
        $display("FAIL en_off: an=%b seg=%b idx=%0d, required 0 0 %0d",
                 bus.an, bus.seg, bus.digit_idx, slot);
      end
    end
    bus.en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.an !== 4'(1 << slot) || bus.digit_idx !== 3'(slot)) begin
        errors++;
        $display("FAIL en_resume: an=%b idx=%0d, required %b %0d",
                 bus.an, bus.digit_idx, 4'(1 << slot), slot);
      end
    end
    step();
    checks++;
    if (bus.an !== 4'b0 || bus.digit_idx !== 3'((slot + 1) % ND)) begin
      errors++;
      $display("FAIL en_next: an=%b idx=%0d, required 0 %0d",
               bus.an, bus.digit_idx, (slot + 1) % ND);
    end
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.an !== 4'b0 || bus.seg !== 7'b0 || bus.dp !== 1'b0 ||
        bus.digit_idx !== 3'd0 || bus.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: an=%b seg=%b dp=%b idx=%0d fs=%b, required zeros",
               bus.an, bus.seg, bus.dp, bus.digit_idx, bus.frame_start);
    end
    repeat (2) step();
    rst = 1'b0;
    for (int c = 1; c <= FR; c++) begin
      step();
      checks++;
      if (bus.an !== e_an || bus.seg !== e_seg ||
          (c == 3 && bus.an !== 4'b0001)) begin
        errors++;
        $display("FAIL post_reset c=%0d: an=%b seg=%b, required an=%b seg=%b",
                 c, bus.an, bus.seg, e_an, e_seg);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        v = 16'($urandom);
        v = v >> (4 * $urandom_range(0, 3));
        bus.bcd_in = v;
      end
      if ($urandom_range(0, 31) == 0) bus.dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) bus.blank_mask = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 31) == 0) bus.blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.lz_blank = 1'($urandom);
      bus.en = ($urandom_range(0, 9) != 0);
      step();
      checks++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.dp !== e_dp ||
          bus.digit_idx !== e_idx || bus.frame_start !== e_fs) begin
        errors++;
        $display("FAIL random c=%0d: an=%b seg=%b dp=%b idx=%0d fs=%b, required %b %b %b %0d %b",
                 c, bus.an, bus.seg, bus.dp, bus.digit_idx, bus.frame_start,
                 e_an, e_seg, e_dp, e_idx, e_fs);
      end
    end
    bus.en = 1'b1;
  endtask

  initial begin
    tbl[0]  = 7'b0111111; tbl[1]  = 7'b0000110;
    tbl[2]  = 7'b1011011; tbl[3]  = 7'b1001111;
    tbl[4]  = 7'b1100110; tbl[5]  = 7'b1101101;
    tbl[6]  = 7'b1111101; tbl[7]  = 7'b0000111;
    tbl[8]  = 7'b1111111; tbl[9]  = 7'b1101111;
    for (int i = 10; i < 16; i++) tbl[i] = 7'b1000000;
    test_reset();
    test_scan();
    test_lz();
    test_snapshot();
    test_blink();
    test_dp();
    test_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
